// File: rtl/uart_pkt_pkg.sv
// Shared types for the UART packet deframer: FSM states, status codes, default sync marker.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    CMD     = 3'd1,
    LEN_LO  = 3'd2,
    LEN_HI  = 3'd3,
    PAYLOAD = 3'd4,
    CHK     = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    ERR_CHK  = 3'd1,
    ERR_FRM  = 3'd2,
    ERR_OVR  = 3'd3,
    ERR_LEN  = 3'd4,
    ERR_TMO  = 3'd5
  } err_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/sync_fifo.sv
// Same-clock FIFO; a write shows on empty/pop_data the next cycle, push and pop may coincide.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_pkt_deframer.sv
// Parses SYNC/CMD/LEN/payload/CHK packets from uart_rx into a header strobe,
// a buffered valid/ready payload stream with last marker, and a done/ok/error status strobe.
module uart_pkt_deframer
  import uart_pkt_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
  parameter int         MAX_LEN     = 4096,
  parameter int         FIFO_DEPTH  = 16,
  parameter int         TIMEOUT_CYC = 1_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_frm_err,
  output logic        o_hdr_valid,
  output logic [7:0]  o_cmd,
  output logic [15:0] o_len,
  output logic [7:0]  o_pl_data,
  output logic        o_pl_last,
  output logic        o_pl_valid,
  input  logic        i_pl_ready,
  output logic        o_pkt_done,
  output logic        o_pkt_ok,
  output logic [2:0]  o_err_code
);

  localparam int              TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0]     MAX_LEN_W = 17'(MAX_LEN);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  state_e        state;
  logic [7:0]    sum;
  logic [7:0]    cmd_r;
  logic [7:0]    len_lo;
  logic [15:0]   remaining;
  logic [TW-1:0] tmo_cnt;
  logic          ovr;

  logic [15:0]   len_rx;
  logic [7:0]    sum_nxt;
  logic          push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [8:0]    fifo_out;

  assign len_rx  = {i_rx_data, len_lo};
  assign sum_nxt = sum + i_rx_data;
  // A byte arriving while full is dropped here; the FSM still counts and sums it.
  assign push    = i_rx_valid && !i_rx_frm_err && (state == PAYLOAD) && !fifo_full;

  sync_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .push_data ({remaining == 16'd1, i_rx_data}),
    .pop       (i_pl_ready),
    .pop_data  (fifo_out),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign o_pl_valid = !fifo_empty;
  assign o_pl_last  = fifo_out[8];
  assign o_pl_data  = fifo_out[7:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= HUNT;
      sum         <= '0;
      cmd_r       <= '0;
      len_lo      <= '0;
      remaining   <= '0;
      tmo_cnt     <= '0;
      ovr         <= 1'b0;
      o_hdr_valid <= 1'b0;
      o_cmd       <= '0;
      o_len       <= '0;
      o_pkt_done  <= 1'b0;
      o_pkt_ok    <= 1'b0;
      o_err_code  <= ERR_NONE;
    end else begin
      o_hdr_valid <= 1'b0;
      o_pkt_done  <= 1'b0;
      o_pkt_ok    <= 1'b0;
      o_err_code  <= ERR_NONE;
      if (state == HUNT) tmo_cnt <= '0;

      if (i_rx_valid && i_rx_frm_err && (state != HUNT)) begin
        state      <= HUNT;
        o_pkt_done <= 1'b1;
        o_err_code <= ERR_FRM;
      end else if (i_rx_valid) begin
        tmo_cnt <= '0;
        case (state)
          HUNT: begin
            if (i_rx_data == SYNC_BYTE) begin
              state <= CMD;
              ovr   <= 1'b0;
            end
          end
          CMD: begin
            cmd_r <= i_rx_data;
            sum   <= i_rx_data;
            state <= LEN_LO;
          end
          LEN_LO: begin
            len_lo <= i_rx_data;
            sum    <= sum_nxt;
            state  <= LEN_HI;
          end
          LEN_HI: begin
            sum <= sum_nxt;
            if ({1'b0, len_rx} > MAX_LEN_W) begin
              state      <= HUNT;
              o_pkt_done <= 1'b1;
              o_err_code <= ERR_LEN;
            end else begin
              o_cmd       <= cmd_r;
              o_len       <= len_rx;
              o_hdr_valid <= 1'b1;
              remaining   <= len_rx;
              state       <= (len_rx == 16'd0) ? CHK : PAYLOAD;
            end
          end
          PAYLOAD: begin
            sum       <= sum_nxt;
            remaining <= remaining - 16'd1;
            if (fifo_full) ovr <= 1'b1;
            if (remaining == 16'd1) state <= CHK;
          end
          CHK: begin
            state      <= HUNT;
            o_pkt_done <= 1'b1;
            o_pkt_ok   <= !ovr && (i_rx_data == sum);
            o_err_code <= ovr ? ERR_OVR : ((i_rx_data != sum) ? ERR_CHK : ERR_NONE);
          end
          default: state <= HUNT;
        endcase
      end else if (state != HUNT) begin
        if (tmo_cnt == TMO_LAST) begin
          state      <= HUNT;
          o_pkt_done <= 1'b1;
          o_err_code <= ERR_TMO;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_pkt_deframer.sv
// Directed packets against uart_pkt_deframer; expected header/payload/status go into queues
// and a negedge monitor pops and compares whenever the DUT presents an output.
module tb_uart_pkt_deframer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_frm_err = 1'b0;
  logic        hdr_valid;
  logic [7:0]  cmd;
  logic [15:0] len;
  logic [7:0]  pl_data;
  logic        pl_last;
  logic        pl_valid;
  logic        pl_ready = 1'b1;
  logic        pkt_done;
  logic        pkt_ok;
  logic [2:0]  err_code;

  always #5 clk = ~clk;

  uart_pkt_deframer #(
    .SYNC_BYTE   (8'hA5),
    .MAX_LEN     (4096),
    .FIFO_DEPTH  (16),
    .TIMEOUT_CYC (1000)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .i_rx_frm_err (rx_frm_err),
    .o_hdr_valid  (hdr_valid),
    .o_cmd        (cmd),
    .o_len        (len),
    .o_pl_data    (pl_data),
    .o_pl_last    (pl_last),
    .o_pl_valid   (pl_valid),
    .i_pl_ready   (pl_ready),
    .o_pkt_done   (pkt_done),
    .o_pkt_ok     (pkt_ok),
    .o_err_code   (err_code)
  );

  logic [23:0] hdr_q[$];
  logic [8:0]  pl_q[$];
  logic [3:0]  done_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: unexpected output %h, nothing expected", name, act);
  endtask

  // Monitor: outputs change on posedge, so negedge sees a stable cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (hdr_valid) begin
        if (hdr_q.size() == 0) unexpected("hdr", {8'h0, cmd, len});
        else check("hdr", {8'h0, cmd, len}, {8'h0, hdr_q.pop_front()});
      end
      if (pl_valid && pl_ready) begin
        if (pl_q.size() == 0) unexpected("payload", {23'h0, pl_last, pl_data});
        else check("payload", {23'h0, pl_last, pl_data}, {23'h0, pl_q.pop_front()});
      end
      if (pkt_done) begin
        if (done_q.size() == 0) unexpected("done", {28'h0, pkt_ok, err_code});
        else check("done", {28'h0, pkt_ok, err_code}, {28'h0, done_q.pop_front()});
      end else if (pkt_ok) begin
        unexpected("ok_without_done", 32'h1);
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic frm = 1'b0);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1; rx_frm_err = frm;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_frm_err = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send(s[i]);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_q.size() != 0 && n < budget) begin
      @(posedge clk); n++;
    end
    check({name, "_done_seen"}, done_q.size(), 0);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((hdr_q.size() + pl_q.size() + done_q.size()) != 0 && n < budget) begin
      @(posedge clk); n++;
    end
    check({name, "_drained"}, hdr_q.size() + pl_q.size() + done_q.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic frame1(input logic [7:0] chk, input logic [3:0] status);
    hdr_q.push_back({8'h01, 16'd3});
    pl_q.push_back({1'b0, 8'h11});
    pl_q.push_back({1'b0, 8'h22});
    pl_q.push_back({1'b1, 8'h33});
    done_q.push_back(status);
    send_seq('{8'hA5, 8'h01, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, chk});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          {hdr_valid, cmd, len, pl_valid, pkt_done, pkt_ok, err_code},
          32'h0);

    // Good frame, checksum 01+03+00+11+22+33 = 6A
    frame1(8'h6A, {1'b1, 3'd0});
    drain("good", 200);

    // Bad checksum: payload still streams
    frame1(8'h6B, {1'b0, 3'd1});
    drain("bad_chk", 200);

    // Noise before sync, zero-length packet
    hdr_q.push_back({8'h07, 16'd0});
    done_q.push_back({1'b1, 3'd0});
    send_seq('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h07, 8'h00, 8'h00, 8'h07});
    drain("len0", 200);

    // Overrun: LEN=20 with consumer stalled; bytes 17..20 dropped, last marker lost
    pl_ready = 1'b0;
    hdr_q.push_back({8'h02, 16'd20});
    for (int i = 1; i <= 16; i++) pl_q.push_back({1'b0, 8'(i)});
    done_q.push_back({1'b0, 3'd3});
    send_seq('{8'hA5, 8'h02, 8'h14, 8'h00});
    for (int i = 1; i <= 20; i++) send(8'(i));
    send(8'h00);
    wait_done("ovr", 200);
    check("ovr_fifo_holds", {31'h0, pl_valid}, 32'h1);
    @(posedge clk); #1 pl_ready = 1'b1;
    drain("ovr", 200);
    check("ovr_fifo_empty", {31'h0, pl_valid}, 32'h0);

    // Framing error on payload byte 2, then a clean frame
    hdr_q.push_back({8'h01, 16'd3});
    pl_q.push_back({1'b0, 8'h11});
    done_q.push_back({1'b0, 3'd2});
    send_seq('{8'hA5, 8'h01, 8'h03, 8'h00, 8'h11});
    send(8'h22, 1'b1);
    drain("frm", 200);
    frame1(8'h6A, {1'b1, 3'd0});
    drain("after_frm", 200);

    // Timeout after header
    hdr_q.push_back({8'h01, 16'd5});
    done_q.push_back({1'b0, 3'd5});
    send_seq('{8'hA5, 8'h01, 8'h05, 8'h00});
    drain("tmo", 1500);

    // LEN=5000 rejected, no header strobe
    done_q.push_back({1'b0, 3'd4});
    send_seq('{8'hA5, 8'h01, 8'h88, 8'h13});
    drain("len5000", 200);

    // LEN=4096 is legal (header accepted), then aborted by framing error
    hdr_q.push_back({8'h01, 16'd4096});
    done_q.push_back({1'b0, 3'd2});
    send_seq('{8'hA5, 8'h01, 8'h00, 8'h10});
    send(8'h33, 1'b1);
    drain("len4096", 200);

    // LEN=4097 rejected
    done_q.push_back({1'b0, 3'd4});
    send_seq('{8'hA5, 8'h01, 8'h01, 8'h10});
    drain("len4097", 200);

    // Reset mid-frame discards it silently; next frame is clean
    send_seq('{8'hA5, 8'h01, 8'h03});
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    frame1(8'h6A, {1'b1, 3'd0});
    drain("after_rst", 200);

    check("final_fifo_empty", {31'h0, pl_valid}, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
